// File: rtl/guess_input_cond.sv
`default_nettype none
// ============================================================================
// Module   : guess_input_cond
// Brief    : Synchronises and debounces a pushbutton and five slide switches,
//            and draws non-repeating 1..30 targets from a free-running LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module guess_input_cond #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_n,
    input  logic [4:0] sw_raw,
    input  logic       next_req,
    output logic       pb_level,
    output logic       pb_press,
    output logic [4:0] sw_stable,
    output logic       sw_changed,
    output logic [4:0] target,
    output logic       target_valid
);

    localparam int unsigned      CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_DRAW = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    logic             pb_sync1_q, pb_sync1_d, pb_sync2_q, pb_sync2_d;
    logic             pb_level_q, pb_level_d, pb_prev_q, pb_prev_d;
    logic             pb_press_q, pb_press_d;
    logic [CNT_W-1:0] pb_cnt_q, pb_cnt_d;

    logic [4:0]       sw_sync1_q, sw_sync1_d, sw_sync2_q, sw_sync2_d;
    logic [4:0]       sw_last_q, sw_last_d;
    logic [4:0]       sw_stable_q, sw_stable_d, sw_prev_q, sw_prev_d;
    logic             sw_changed_q, sw_changed_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d, sw_base;

    logic [7:0]       lfsr_q, lfsr_d;
    logic [4:0]       cand;
    logic             cand_ok;

    state_t           state_q;
    logic [4:0]       target_q;
    logic             target_valid_q;
    logic             hist_q;

    always_comb begin
        pb_sync1_d = pb_n;
        pb_sync2_d = pb_sync1_q;
        pb_level_d = pb_level_q;
        pb_cnt_d   = '0;
        if (pb_sync2_q != pb_level_q) begin
            if (pb_cnt_q == CNT_LAST) begin
                pb_level_d = pb_sync2_q;
            end else begin
                pb_cnt_d = pb_cnt_q + 1'b1;
            end
        end
        pb_prev_d  = pb_level_q;
        pb_press_d = pb_prev_q & ~pb_level_q;

        // A change of the synced vector restarts the count; that cycle is the first of the run.
        sw_sync1_d  = sw_raw;
        sw_sync2_d  = sw_sync1_q;
        sw_base     = (sw_sync2_q != sw_last_q) ? '0 : sw_cnt_q;
        sw_stable_d = sw_stable_q;
        sw_cnt_d    = '0;
        if (sw_sync2_q != sw_stable_q) begin
            if (sw_base == CNT_LAST) begin
                sw_stable_d = sw_sync2_q;
            end else begin
                sw_cnt_d = sw_base + 1'b1;
            end
        end
        sw_last_d    = sw_sync2_q;
        sw_prev_d    = sw_stable_q;
        sw_changed_d = (sw_prev_q != sw_stable_q);

        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        cand    = lfsr_q[4:0];
        cand_ok = (cand != 5'd0) && (cand <= 5'd30) && (!hist_q || (cand != target_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pb_sync1_q   <= 1'b1;
            pb_sync2_q   <= 1'b1;
            pb_level_q   <= 1'b1;
            pb_prev_q    <= 1'b1;
            pb_press_q   <= 1'b0;
            pb_cnt_q     <= '0;
            sw_sync1_q   <= '0;
            sw_sync2_q   <= '0;
            sw_last_q    <= '0;
            sw_stable_q  <= '0;
            sw_prev_q    <= '0;
            sw_changed_q <= 1'b0;
            sw_cnt_q     <= '0;
            lfsr_q       <= LFSR_SEED;
        end else begin
            pb_sync1_q   <= pb_sync1_d;
            pb_sync2_q   <= pb_sync2_d;
            pb_level_q   <= pb_level_d;
            pb_prev_q    <= pb_prev_d;
            pb_press_q   <= pb_press_d;
            pb_cnt_q     <= pb_cnt_d;
            sw_sync1_q   <= sw_sync1_d;
            sw_sync2_q   <= sw_sync2_d;
            sw_last_q    <= sw_last_d;
            sw_stable_q  <= sw_stable_d;
            sw_prev_q    <= sw_prev_d;
            sw_changed_q <= sw_changed_d;
            sw_cnt_q     <= sw_cnt_d;
            lfsr_q       <= lfsr_d;
        end
    end

    // hist_q marks that target_q holds a real previous draw to avoid repeating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_DRAW;
            target_q       <= 5'd0;
            target_valid_q <= 1'b0;
            hist_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_DRAW: begin
                    if (cand_ok) begin
                        target_q       <= cand;
                        target_valid_q <= 1'b1;
                        hist_q         <= 1'b1;
                        state_q        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (next_req) begin
                        target_valid_q <= 1'b0;
                        state_q        <= ST_DRAW;
                    end
                end
                default: state_q <= ST_DRAW;
            endcase
        end
    end

    assign pb_level     = pb_level_q;
    assign pb_press     = pb_press_q;
    assign sw_stable    = sw_stable_q;
    assign sw_changed   = sw_changed_q;
    assign target       = target_q;
    assign target_valid = target_valid_q;

endmodule
`default_nettype wire

// File: doc/guess_input_cond.md
GUESS_INPUT_COND -- requirements
Module: guess_input_cond

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 500000, meaning stable-cycle count required to accept a new pb/sw level (10 ms at 50 MHz).
REQ-002 SHALL have parameter LFSR_SEED, default 8'hA5, meaning LFSR value loaded on reset; must be nonzero.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pb_n  input  1  raw pushbutton, active-low, asynchronous to clk, bouncing.
REQ-006 SHALL have port sw_raw  input  5  raw slide switches, asynchronous to clk, bouncing.
REQ-007 SHALL have port next_req  input  1  synchronous single-cycle request for a new target.
REQ-008 SHALL have port pb_level  output  1  debounced pushbutton level, 1 = released.
REQ-009 SHALL have port pb_press  output  1  one-cycle pulse on debounced press (1->0).
REQ-010 SHALL have port sw_stable  output  5  debounced switch vector.
REQ-011 SHALL have port sw_changed  output  1  one-cycle pulse when sw_stable updates.
REQ-012 SHALL have port target  output  5  current target number, 1..30.
REQ-013 SHALL have port target_valid  output  1  target holds a valid, accepted draw.

Function
REQ-014 SHALL pass pb_n and each sw_raw bit through a 2-flop synchronizer before any other use.
REQ-015 SHALL debounce pb: counter clears whenever synced pb equals pb_level; otherwise increments; on the cycle counter reaches DEB_CYCLES-1 with synced pb still differing, pb_level takes the synced value and counter clears.
REQ-016 SHALL assert pb_press for exactly one cycle, the cycle after pb_level goes 1->0; release (0->1) SHALL produce no pulse.
REQ-017 SHALL debounce sw as one 5-bit vector with its own counter: any change of the synced vector during counting restarts the count at 0; sw_stable updates only after DEB_CYCLES consecutive cycles of an identical synced vector differing from sw_stable.
REQ-018 SHALL assert sw_changed for exactly one cycle, the cycle after sw_stable updates.
REQ-019 SHALL debounce counters be wide enough for DEB_CYCLES and never wrap.
REQ-020 SHALL run an 8-bit Fibonacci LFSR, advancing every clk cycle: fb = l[7]^l[5]^l[4]^l[3], next = {l[6:0], fb}; all-zero state SHALL be unreachable.
REQ-021 SHALL implement target FSM with states DRAW and HOLD.
REQ-022 In DRAW, each cycle SHALL sample candidate = current lfsr[4:0]; accept iff 1 <= candidate <= 30 and (target_valid history empty or candidate != last accepted target).
REQ-023 On accept, SHALL register target = candidate, target_valid = 1, next state HOLD; on reject, remain DRAW, target and target_valid unchanged.
REQ-024 In HOLD, next_req = 1 SHALL clear target_valid on the next edge and move to DRAW; target retains its old value while in DRAW.
REQ-025 next_req SHALL be ignored while in DRAW; a draw SHALL complete within 255 cycles of entering DRAW.
REQ-026 pb_press, sw_changed and FSM operation SHALL be independent; simultaneous events SHALL all take effect in the same cycle.

Reset
REQ-027 While rst = 0: synchronizer flops = 1 (pb) / 0 (sw), pb_level = 1, pb_press = 0, sw_stable = 0, sw_changed = 0, counters = 0, lfsr = LFSR_SEED, target = 0, target_valid = 0, FSM = DRAW, last-target history empty.
REQ-028 Reset asserted mid-debounce or mid-draw SHALL abort immediately to REQ-027 values with no output pulse.

Verification
REQ-029 DEB_CYCLES=4, default seed: release rst -> first rising edge gives target=5, target_valid=1, FSM HOLD.
REQ-030 DEB_CYCLES=4: pb_n bounces 1,0,1,0 each for 2 cycles then held 0 -> exactly one pb_press, 2+4 cycles (plus pulse register) after last bounce; no pulse on later release.
REQ-031 DEB_CYCLES=4: sw_raw 0->5'd12 with one-cycle glitch to 5'd13 during count -> sw_stable ends 12, sw_changed pulses once, never shows 13.
REQ-032 In HOLD with target=5, pulse next_req 1000 times -> every draw in 1..30, never equal to previous, each within 255 cycles; next_req during DRAW has no effect.
REQ-033 Assert rst during pb debounce count and during DRAW -> all outputs to reset values at once; after release sequence repeats REQ-029.
